mem_stage_ctrl: RTL
===================

Name: mem_stage_ctrl

Overview:
- Pipeline-side request controller that sits directly upstream of mem_system.
- Accepts one load/store per instruction from the MEM stage and screens it for illegal or misaligned requests.
- Presents the request to mem_system as registered Rd/Wr/Addr/DataIn, held until Done, and stalls the pipeline meanwhile.
- Returns read data, keeps access/hit statistics, and traps memory errors and hung requests.

Parameters:
- TIMEOUT, 64, number of REQ-state cycles without Done before a timeout error; legal range 2..255.
- CNT_W, 16, width of the access and hit counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- pipe_valid  in  1  MEM stage holds a memory instruction
- pipe_rd  in  1  load request
- pipe_wr  in  1  store request
- pipe_addr  in  16  byte address
- pipe_wdata  in  16  store data
- pipe_stall  out  1  freeze pipeline
- rdata  out  16  load result
- rdata_valid  out  1  rdata valid, one-cycle pulse
- align_err  out  1  misaligned or illegal request, one-cycle pulse
- fatal_err  out  1  sticky memory error or timeout
- mem_addr  out  16  to mem_system Addr
- mem_wdata  out  16  to mem_system DataIn
- mem_rd  out  1  to mem_system Rd
- mem_wr  out  1  to mem_system Wr
- mem_done  in  1  from mem_system Done
- mem_rdata  in  16  from mem_system DataOut
- mem_hit  in  1  from mem_system CacheHit
- mem_err  in  1  from mem_system err
- access_cnt  out  CNT_W  completed accesses
- hit_cnt  out  CNT_W  completed accesses that hit

Behaviour:
- Reset values (async, rst_n=0): state=IDLE; all outputs 0, including rdata, counters and timeout counter. Reset mid-request drops mem_rd/mem_wr immediately; the request is lost.
- Legal request: pipe_valid & (pipe_rd ^ pipe_wr) & ~pipe_addr[0].
- Illegal request: pipe_valid & pipe_rd & pipe_wr.
- Misaligned request: pipe_valid & either rd/wr & pipe_addr[0].
- State machine: IDLE, REQ, RESP, ERR.
- IDLE:
  - pipe_stall = legal request (combinational) so the instruction holds.
  - Legal request: latch addr, wdata and rd/wr; clear timeout counter; go to REQ.
  - Illegal or misaligned request: pulse align_err the same cycle (combinational); issue no request; no stall; stay IDLE.
  - pipe_valid=0 or rd=wr=0: idle, no outputs.
- REQ:
  - mem_rd/mem_wr driven from the latched rd/wr; mem_addr/mem_wdata from the latched values, stable for the whole state; pipe_stall=1.
  - Timeout counter increments each cycle.
  - mem_err=1 (priority over mem_done): go to ERR.
  - Else mem_done=1: rdata <= mem_rdata for loads (unchanged for stores); access_cnt+1; hit_cnt+1 if mem_hit; go to RESP.
  - Else counter == TIMEOUT-1: go to ERR.
  - mem_rd/mem_wr are asserted through the mem_done cycle inclusive and deasserted in RESP.
- RESP (exactly 1 cycle):
  - pipe_stall=0; rdata_valid=1 only if the access was a load.
  - Pipe inputs are ignored; they belong to the completing instruction. Go to IDLE.
- ERR: fatal_err=1 and pipe_stall=1 permanently; mem_rd/mem_wr=0; exit only by reset.
- Counters saturate at all-ones; no wrap.
- Minimum latency: request accepted at cycle N, mem_rd asserted at N+1; if mem_done at N+1, RESP at N+2 and a back-to-back request is accepted at N+3.
- mem_done or mem_err outside REQ is ignored.
- rdata holds its last value between loads.

Test Plan:
- Aligned load: addr 0x0010, mem_done 1 cycle after mem_rd with mem_rdata 0xBEEF, mem_hit=1 -> mem_rd high for exactly 1 cycle; rdata=0xBEEF with rdata_valid pulse; pipe_stall high 2 cycles; access_cnt=1, hit_cnt=1.
- Store miss: wr to 0x0A22 data 0x1234, mem_done after 12 cycles with mem_hit=0 -> mem_wr, mem_addr and mem_wdata stable 12 cycles; no rdata_valid; access_cnt+1, hit_cnt unchanged.
- Misaligned load to 0x0011, then pipe_rd=pipe_wr=1 to 0x0020 -> align_err pulse each cycle; mem_rd/mem_wr never asserted; pipe_stall=0; counters unchanged.
- Timeout: TIMEOUT=8, load with no mem_done -> ERR after 8 REQ cycles; fatal_err=1, pipe_stall=1 and mem_rd=0 held until rst_n low.
- mem_err and mem_done asserted in the same cycle -> ERR; rdata and counters not updated.
- Mid-request reset: rst_n low during REQ cycle 3 -> mem_rd=0 asynchronously; all outputs 0; back in IDLE after release. Saturation: preload by 65540 hits -> access_cnt=hit_cnt=0xFFFF.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//   Request controller between the pipeline MEM stage and mem_system.
//   Screens each load/store for misalignment or rd+wr conflicts, presents
//   legal requests to mem_system as registered Rd/Wr/Addr/DataIn until Done,
//   stalls the pipeline meanwhile, returns load data and keeps access/hit
//   statistics. Memory errors and hung requests lock the block in ERR.
//
//   State table
//     state | meaning
//     IDLE  | waiting for a MEM-stage instruction; screens it combinationally
//     REQ   | request presented to mem_system, waiting for Done/err/timeout
//     RESP  | one-cycle completion slot; pipeline released, load data valid
//     ERR   | memory error or timeout; pipeline frozen until reset
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   pipe_valid/rd/wr/addr/wdata MEM-stage request
//   pipe_stall                  freeze the pipeline
//   rdata, rdata_valid          load result and its one-cycle valid pulse
//   align_err                   misaligned / illegal request pulse
//   fatal_err                   sticky memory error or timeout
//   mem_addr/wdata/rd/wr        request to mem_system
//   mem_done/rdata/hit/err      response from mem_system
//   access_cnt, hit_cnt         saturating statistics counters
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pipe_valid,
    input  logic             pipe_rd,
    input  logic             pipe_wr,
    input  logic [15:0]      pipe_addr,
    input  logic [15:0]      pipe_wdata,
    output logic             pipe_stall,
    output logic [15:0]      rdata,
    output logic             rdata_valid,
    output logic             align_err,
    output logic             fatal_err,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    output logic             mem_rd,
    output logic             mem_wr,
    input  logic             mem_done,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_hit,
    input  logic             mem_err,
    output logic [CNT_W-1:0] access_cnt,
    output logic [CNT_W-1:0] hit_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

    localparam logic [7:0]       TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t     state;
    logic [7:0] to_cnt;
    logic       is_rd;
    logic       legal;
    logic       bad;

    assign legal = pipe_valid & (pipe_rd ^ pipe_wr) & ~pipe_addr[0];
    assign bad   = pipe_valid & ((pipe_rd & pipe_wr) | ((pipe_rd | pipe_wr) & pipe_addr[0]));

    // Stall and align_err must react in the same cycle the instruction shows
    // up, so they are decoded from the current state rather than registered.
    always_comb begin
        pipe_stall = 1'b0;
        align_err  = 1'b0;
        case (state)
            IDLE: begin
                pipe_stall = legal;
                align_err  = bad;
            end
            REQ:     pipe_stall = 1'b1;
            ERR:     pipe_stall = 1'b1;
            default: pipe_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            to_cnt      <= '0;
            is_rd       <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            fatal_err   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            access_cnt  <= '0;
            hit_cnt     <= '0;
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (legal) begin
                        mem_addr  <= pipe_addr;
                        mem_wdata <= pipe_wdata;
                        mem_rd    <= pipe_rd;
                        mem_wr    <= pipe_wr;
                        is_rd     <= pipe_rd;
                        to_cnt    <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    to_cnt <= to_cnt + 8'd1;
                    if (mem_err) begin
                        mem_rd    <= 1'b0;
                        mem_wr    <= 1'b0;
                        fatal_err <= 1'b1;
                        state     <= ERR;
                    end else if (mem_done) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (is_rd) begin
                            rdata       <= mem_rdata;
                            rdata_valid <= 1'b1;
                        end
                        if (access_cnt != '1)
                            access_cnt <= access_cnt + CNT_ONE;
                        if (mem_hit && (hit_cnt != '1))
                            hit_cnt <= hit_cnt + CNT_ONE;
                        state <= RESP;
                    end else if (to_cnt == TO_LAST) begin
                        mem_rd    <= 1'b0;
                        mem_wr    <= 1'b0;
                        fatal_err <= 1'b1;
                        state     <= ERR;
                    end
                end
                RESP: state <= IDLE;
                ERR: begin
                    fatal_err <= 1'b1;
                    mem_rd    <= 1'b0;
                    mem_wr    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
